// File: rtl/tinyfpga_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinyfpga_cfg_pkg
//  Description : Shared types, constants and the serial CRC-8 step function
//                for the tinyFPGA configuration loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinyfpga_cfg_pkg;

    // Loader state encoding; explicit 3-bit width.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int             CRC_W    = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    // One MSB-first CRC-8 step: feedback is the outgoing top bit xor the new bit.
    function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic w_fb;
        w_fb = crc[CRC_W-1] ^ din;
        crc8_next = {crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tinyfpga_cfg_loader_crc8.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial
//  Description : Bit-serial CRC-8 accumulator with synchronous clear and
//                enable. Clear wins over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
    import tinyfpga_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_din,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] r_crc;

    // Accumulate one bit per enabled cycle; clear restarts from the 0x00 seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= crc8_next(r_crc, i_din);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/tinyfpga_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tinyfpga_cfg_loader
//  Description : Serial configuration loader. Shifts a CHAIN_LEN + 8 bit
//                stream into a shadow chain, verifies length and CRC-8, then
//                commits the data to the active configuration and sequences
//                the fabric reset (including a pin-driven user reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tinyfpga_cfg_loader
    import tinyfpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int RST_HOLD  = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prog_en,
    input  logic                 prog_valid,
    input  logic                 prog_in,
    input  logic                 user_rst,
    output logic                 prog_out,
    output logic [CHAIN_LEN-1:0] cfg,
    output logic                 cfg_valid,
    output logic                 fabric_rst_n,
    output logic                 load_err
);

    localparam int c_cnt_w  = $clog2(CHAIN_LEN + 9);
    localparam int c_hold_w = $clog2(RST_HOLD + 1);
    localparam int c_sh_w   = CHAIN_LEN + CRC_W;

    localparam logic [c_cnt_w-1:0]  c_cnt_data = c_cnt_w'(CHAIN_LEN);
    localparam logic [c_cnt_w-1:0]  c_cnt_full = c_cnt_w'(CHAIN_LEN + CRC_W);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_hold_w-1:0] c_hold     = c_hold_w'(RST_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_prog_en_q;
    logic                 r_armed;
    logic                 r_user_rst_q;
    logic [c_sh_w-1:0]    r_shadow;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf;
    logic [c_hold_w-1:0]  r_hold;
    logic                 r_prog_out;
    logic [CHAIN_LEN-1:0] r_cfg;
    logic                 r_cfg_valid;
    logic                 r_fabric_rst_n;
    logic                 r_load_err;
    logic [CRC_W-1:0]     w_crc;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_accept;
    logic                 w_enter_shift;
    logic                 w_pass;

    // r_armed masks the first cycle after reset so a prog_en already high
    // at reset exit is not mistaken for a rising edge.
    assign w_rise   = r_armed &  prog_en & ~r_prog_en_q;
    assign w_fall   = r_armed & ~prog_en &  r_prog_en_q;
    // A bit arriving with the closing falling edge is dropped.
    assign w_accept = (r_state == SHIFT) & prog_valid & ~w_fall;
    assign w_enter_shift = (w_state_next == SHIFT) && (r_state != SHIFT);
    // The received CRC occupies the bottom byte of the shadow chain.
    assign w_pass   = (r_cnt == c_cnt_full) && !r_ovf && (w_crc == r_shadow[CRC_W-1:0]);

    // Edge-detect registers for prog_en and user_rst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_en_q  <= 1'b0;
            r_armed      <= 1'b0;
            r_user_rst_q <= 1'b0;
        end else begin
            r_prog_en_q  <= prog_en;
            r_armed      <= 1'b1;
            r_user_rst_q <= user_rst;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_state_next = SHIFT;
            SHIFT:   if (w_fall) w_state_next = CHECK;
            CHECK:   w_state_next = w_pass ? RUN : ERROR;
            RUN:     if (w_rise) w_state_next = SHIFT;
            ERROR:   if (w_rise) w_state_next = SHIFT;
            default: w_state_next = IDLE;
        endcase
    end

    // Shadow chain, bit counter and overflow flag; prog_out takes the chain
    // top before each shift so downstream loaders see a CHAIN_LEN-bit delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_prog_out <= 1'b0;
        end else if (w_enter_shift) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_prog_out <= r_shadow[CHAIN_LEN-1];
            r_shadow   <= {r_shadow[c_sh_w-2:0], prog_in};
            if (r_cnt == c_cnt_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    crc8_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_enter_shift),
        .i_en  (w_accept && (r_cnt < c_cnt_data)),
        .i_din (prog_in),
        .o_crc (w_crc)
    );

    // Commit, status flags and fabric reset sequencing. User reset reloads the
    // hold counter while high and on the first low sample, so the release
    // delay is counted from the cycle user_rst is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg          <= '0;
            r_cfg_valid    <= 1'b0;
            r_fabric_rst_n <= 1'b0;
            r_load_err     <= 1'b0;
            r_hold         <= '0;
        end else if (w_enter_shift) begin
            r_cfg_valid    <= 1'b0;
            r_fabric_rst_n <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            case (r_state)
                CHECK: begin
                    r_fabric_rst_n <= 1'b0;
                    if (w_pass) begin
                        r_cfg       <= r_shadow[c_sh_w-1:CRC_W];
                        r_cfg_valid <= 1'b1;
                        r_load_err  <= 1'b0;
                        r_hold      <= c_hold;
                    end else begin
                        r_cfg_valid <= 1'b0;
                        r_load_err  <= 1'b1;
                    end
                end
                RUN: begin
                    if (user_rst || r_user_rst_q) begin
                        r_hold         <= c_hold;
                        r_fabric_rst_n <= 1'b0;
                    end else if (r_hold != '0) begin
                        r_hold         <= r_hold - c_hold_one;
                        r_fabric_rst_n <= (r_hold == c_hold_one);
                    end else begin
                        r_fabric_rst_n <= 1'b1;
                    end
                end
                default: r_fabric_rst_n <= 1'b0;
            endcase
        end
    end

    assign prog_out     = r_prog_out;
    assign cfg          = r_cfg;
    assign cfg_valid    = r_cfg_valid;
    assign fabric_rst_n = r_fabric_rst_n;
    assign load_err     = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_tinyfpga_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tinyfpga_cfg_loader
//  Description : Self-checking bench for tinyfpga_cfg_loader (CHAIN_LEN=16,
//                RST_HOLD=4). Expected commits and prog_out echoes are queued
//                when stimulus is driven and compared when the DUT responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tinyfpga_cfg_loader;

    localparam int CHAIN_LEN = 16;
    localparam int RST_HOLD  = 4;

    typedef struct packed {
        logic [15:0] cfg;
        logic        valid;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        prog_en;
    logic        prog_valid;
    logic        prog_in;
    logic        user_rst;
    logic        prog_out;
    logic [15:0] cfg;
    logic        cfg_valid;
    logic        fabric_rst_n;
    logic        load_err;

    int          total;
    int          bad;
    logic [15:0] model_cfg;
    exp_t        exp_q[$];
    logic        echo_q[$];

    tinyfpga_cfg_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_en      (prog_en),
        .prog_valid   (prog_valid),
        .prog_in      (prog_in),
        .user_rst     (user_rst),
        .prog_out     (prog_out),
        .cfg          (cfg),
        .cfg_valid    (cfg_valid),
        .fabric_rst_n (fabric_rst_n),
        .load_err     (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC by polynomial long division of data * x^8 mod 0x107.
    function automatic logic [7:0] crc_model(input logic [15:0] d);
        logic [23:0] v;
        v = {d, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (v[i]) v = v ^ (24'h107 << (i - 8));
        end
        return v[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load: entry, nbits bits (each preceded by gap idle cycles), close,
    // commit check and fabric reset release timing.
    task automatic run_load(input logic [15:0] data, input logic [7:0] crc,
                            input int nbits, input int gap, input string name);
        logic [31:0] bits;
        logic        pass;
        logic        want_echo;
        logic [15:0] prev_cfg;
        exp_t        e;
        int          n;

        bits = {8'h00, data, crc};
        if (nbits < 24) bits = bits >> (24 - nbits);
        else            bits = bits << (nbits - 24);
        prev_cfg = model_cfg;
        pass = (nbits == 24) && (crc == crc_model(data));
        if (pass) model_cfg = data;
        e.cfg = model_cfg; e.valid = pass; e.err = !pass;
        exp_q.push_back(e);

        prog_en = 1'b1; prog_valid = 1'b0;
        step();
        total++;
        if ({cfg, cfg_valid, fabric_rst_n, load_err} !== {prev_cfg, 3'b000}) begin
            bad++;
            $display("FAIL %s_entry: cfg=%h v=%b rstn=%b err=%b, want cfg=%h v=0 rstn=0 err=0",
                     name, cfg, cfg_valid, fabric_rst_n, load_err, prev_cfg);
        end

        echo_q.delete();
        for (int i = 0; i < CHAIN_LEN; i++) echo_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gap; g++) begin
                prog_valid = 1'b0;
                step();
            end
            prog_valid = 1'b1;
            prog_in    = bits[nbits - 1 - i];
            echo_q.push_back(bits[nbits - 1 - i]);
            step();
            want_echo = echo_q.pop_front();
            total++;
            if (prog_out !== want_echo) begin
                bad++;
                $display("FAIL %s_echo[%0d]: prog_out=%b want %b", name, i, prog_out, want_echo);
            end
        end

        prog_valid = 1'b0; prog_en = 1'b0;
        step();  // CHECK edge
        total++;
        if (cfg_valid !== 1'b0 || cfg !== prev_cfg) begin
            bad++;
            $display("FAIL %s_check_cycle: cfg=%h v=%b, want cfg=%h v=0", name, cfg, cfg_valid, prev_cfg);
        end
        step();  // commit edge
        e = exp_q.pop_front();
        total++;
        if ({cfg, cfg_valid, load_err, fabric_rst_n} !== {e.cfg, e.valid, e.err, 1'b0}) begin
            bad++;
            $display("FAIL %s_commit: cfg=%h v=%b err=%b rstn=%b, want cfg=%h v=%b err=%b rstn=0",
                     name, cfg, cfg_valid, load_err, fabric_rst_n, e.cfg, e.valid, e.err);
        end

        if (pass) begin
            n = 0;
            while (fabric_rst_n !== 1'b1 && n < 12) begin
                step();
                n++;
            end
            total++;
            if (n != RST_HOLD) begin
                bad++;
                $display("FAIL %s_release: fabric_rst_n rose after %0d edges, want %0d",
                         name, n, RST_HOLD);
            end
        end else begin
            repeat (3) step();
            total++;
            if ({fabric_rst_n, load_err, cfg_valid, cfg} !== {3'b010, prev_cfg}) begin
                bad++;
                $display("FAIL %s_error_hold: rstn=%b err=%b v=%b cfg=%h, want rstn=0 err=1 v=0 cfg=%h",
                         name, fabric_rst_n, load_err, cfg_valid, cfg, prev_cfg);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog_en = 1'b0; prog_valid = 1'b0; prog_in = 1'b0; user_rst = 1'b0;
        model_cfg = 16'h0000;
        repeat (3) step();
        total++;
        if ({cfg, cfg_valid, fabric_rst_n, load_err, prog_out} !== 20'h0) begin
            bad++;
            $display("FAIL reset: cfg=%h v=%b rstn=%b err=%b pout=%b, want all 0",
                     cfg, cfg_valid, fabric_rst_n, load_err, prog_out);
        end
        rst_n = 1'b1;
        repeat (2) step();
        total++;
        if ({cfg_valid, fabric_rst_n, load_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: v=%b rstn=%b err=%b, want 000", cfg_valid, fabric_rst_n, load_err);
        end
    endtask

    task automatic test_good_load();
        run_load(16'h0001, 8'h07, 24, 0, "good");
    endtask

    task automatic test_crc();
        run_load(16'h0100, 8'h14, 24, 0, "badcrc");
        run_load(16'h0100, 8'h15, 24, 0, "goodcrc");
    endtask

    task automatic test_length();
        run_load(16'h0001, 8'h07, 23, 0, "short");
        run_load(16'h0001, 8'h07, 25, 0, "long");
    endtask

    task automatic test_random_loads();
        logic [15:0] d;
        for (int k = 0; k < 3; k++) begin
            d = 16'($urandom);
            run_load(d, crc_model(d), 24, 0, "rand");
        end
        d = 16'($urandom);
        run_load(d, crc_model(d) ^ (8'h01 << $urandom_range(7, 0)), 24, 0, "randbad");
    endtask

    task automatic test_gapped();
        run_load(16'h0001, 8'h07, 24, 2, "gapped");
    endtask

    task automatic test_user_rst();
        int n;
        user_rst = 1'b1;
        step();  // U
        total++;
        if (fabric_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL user_rst_assert: fabric_rst_n=%b want 0", fabric_rst_n);
        end
        step();
        step();
        user_rst = 1'b0;
        step();  // D
        n = 0;
        while (fabric_rst_n !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        total++;
        if (n != RST_HOLD) begin
            bad++;
            $display("FAIL user_rst_release: rose %0d edges after D, want %0d", n, RST_HOLD);
        end
        total++;
        if (cfg !== model_cfg || cfg_valid !== 1'b1) begin
            bad++;
            $display("FAIL user_rst_cfg: cfg=%h v=%b, want cfg=%h v=1", cfg, cfg_valid, model_cfg);
        end
    endtask

    task automatic test_midload_reset();
        prog_en = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            prog_valid = 1'b1;
            prog_in    = 1'($urandom);
            step();
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({cfg, cfg_valid, fabric_rst_n, load_err, prog_out} !== 20'h0) begin
            bad++;
            $display("FAIL midload_reset: cfg=%h v=%b rstn=%b err=%b pout=%b, want all 0",
                     cfg, cfg_valid, fabric_rst_n, load_err, prog_out);
        end
        prog_en = 1'b0; prog_valid = 1'b0;
        model_cfg = 16'h0000;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        run_load(16'h0100, 8'h15, 24, 0, "after_reset");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_good_load();
        test_crc();
        test_length();
        test_random_loads();
        test_gapped();
        test_user_rst();
        test_midload_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
